// File: rtl/mdu_seq_ctrl.sv
// Sequencer for the shared iterative multiply/divide unit feeding HI/LO.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with signs fixed up in SIGN.
module mdu_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             res_valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   b_reg;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  // The borrow out of the WIDTH+1 subtract doubles as the restoring compare.
  always_comb begin
    a_neg     = ~op_i[0] & src_a_i[WIDTH-1];
    b_neg     = ~op_i[0] & src_b_i[WIDTH-1];
    a_abs     = a_neg ? -src_a_i : src_a_i;
    b_abs     = b_neg ? -src_b_i : src_b_i;
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    prod      = {hi_reg, lo_reg};
    prod_neg  = -prod;
  end

  assign stall_o = ((state == IDLE) && start_i && !cancel_i) ||
                   (state == CALC) || (state == SIGN);
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      b_reg       <= '0;
      res_valid_o <= 1'b0;
      div_zero_o  <= 1'b0;
      hi_o        <= '0;
      lo_o        <= '0;
    end else begin
      res_valid_o <= 1'b0;
      div_zero_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !cancel_i) begin
            is_div <= op_i[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= '0;
            hi_reg <= '0;
            lo_reg <= a_abs;
            b_reg  <= b_abs;
            if (op_i[1] && (src_b_i == '0)) begin
              state       <= DONE;
              res_valid_o <= 1'b1;
              div_zero_o  <= 1'b1;
              hi_o        <= src_a_i;
              lo_o        <= '1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cancel_i) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              hi_reg <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
              lo_reg <= {lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
              hi_reg <= mul_sum[WIDTH:1];
              lo_reg <= {mul_sum[0], lo_reg[WIDTH-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= SIGN;
          end
        end
        SIGN: begin
          if (cancel_i) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              lo_o <= neg_q ? -lo_reg : lo_reg;
              hi_o <= neg_r ? -hi_reg : hi_reg;
            end else begin
              {hi_o, lo_o} <= neg_q ? prod_neg : prod;
            end
            res_valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed scenarios plus randomized ops
// checked against a 64-bit arithmetic reference model.
module tb_mdu_seq_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] src_a_i;
  logic [W-1:0] src_b_i;
  logic         cancel_i;
  logic         stall_o;
  logic         busy_o;
  logic         res_valid_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         div_zero_o;

  int tests = 0;
  int fails = 0;

  mdu_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .cancel_i(cancel_i),
    .stall_o(stall_o), .busy_o(busy_o), .res_valid_o(res_valid_o),
    .hi_o(hi_o), .lo_o(lo_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: full-precision arithmetic, results truncated to HI/LO.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo,
                       output logic dz, output int lat);
    longint       sa, sb, q, r;
    logic [63:0]  p, qv, rv;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    dz = 1'b0;
    lat = W + 2;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          hi = a; lo = '1; dz = 1'b1; lat = 1;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb; qv = q; rv = r;
          lo = qv[31:0]; hi = rv[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz,
                               output int lat, output int stallCycles, output logic stallAtValid,
                               output logic gotValid);
    hi = '0; lo = '0; dz = 1'b0; lat = 0; stallCycles = 0; stallAtValid = 1'b0; gotValid = 1'b0;
    @(negedge clk);
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    #1;
    if (stall_o) stallCycles++;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int c = 1; c <= 100 && !gotValid; c++) begin
      @(negedge clk);
      if (res_valid_o) begin
        gotValid = 1'b1; lat = c; hi = hi_o; lo = lo_o; dz = div_zero_o; stallAtValid = stall_o;
      end else if (stall_o) begin
        stallCycles++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; op_i = '0; src_a_i = '0; src_b_i = '0;
    #3;
    tests++;
    if ({stall_o, busy_o, res_valid_o, div_zero_o, hi_o, lo_o} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got st=%b bz=%b rv=%b dz=%b hi=%h lo=%h, expected all 0",
               stall_o, busy_o, res_valid_o, div_zero_o, hi_o, lo_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mult();
    logic [W-1:0] hi, lo;
    logic dz, sav, ok;
    int lat, sc;
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, hi, lo, dz, lat, sc, sav, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL multu_valid: got %b expected 1", ok); end
    tests++; if (lat != 34) begin fails++; $display("[TB] FAIL multu_latency: got %0d expected 34", lat); end
    tests++; if (sc != 34) begin fails++; $display("[TB] FAIL multu_stall_cycles: got %0d expected 34", sc); end
    tests++; if (sav !== 1'b0) begin fails++; $display("[TB] FAIL multu_stall_in_done: got %b expected 0", sav); end
    tests++; if (hi !== 32'hFFFFFFFE) begin fails++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", hi); end
    tests++; if (lo !== 32'h00000001) begin fails++; $display("[TB] FAIL multu_lo: got %h expected 00000001", lo); end
    tests++; if (dz !== 1'b0) begin fails++; $display("[TB] FAIL multu_dz: got %b expected 0", dz); end
    @(negedge clk);
    tests++;
    if ({res_valid_o, busy_o, hi_o, lo_o} !== {1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001}) begin
      fails++;
      $display("[TB] FAIL multu_after_pulse: got rv=%b bz=%b hi=%h lo=%h expected rv=0 bz=0 hi=fffffffe lo=00000001",
               res_valid_o, busy_o, hi_o, lo_o);
    end
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd7, hi, lo, dz, lat, sc, sav, ok);
    tests++;
    if ({ok, hi, lo} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB}) begin
      fails++;
      $display("[TB] FAIL mult_neg: got v=%b hi=%h lo=%h expected v=1 hi=ffffffff lo=ffffffeb", ok, hi, lo);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] hi, lo;
    logic dz, sav, ok;
    int lat, sc;
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, hi, lo, dz, lat, sc, sav, ok);
    tests++;
    if ({ok, dz, hi, lo} !== {1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      fails++;
      $display("[TB] FAIL div_neg: got v=%b dz=%b hi=%h lo=%h expected v=1 dz=0 hi=ffffffff lo=fffffffd", ok, dz, hi, lo);
    end
    applyStimulus(2'b11, 32'd100, 32'd7, hi, lo, dz, lat, sc, sav, ok);
    tests++;
    if ({ok, hi, lo} !== {1'b1, 32'd2, 32'd14}) begin
      fails++;
      $display("[TB] FAIL divu_100_7: got v=%b hi=%0d lo=%0d expected v=1 hi=2 lo=14", ok, hi, lo);
    end
    tests++; if (lat != 34) begin fails++; $display("[TB] FAIL divu_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] hi, lo;
    logic dz, sav, ok;
    int lat, sc;
    applyStimulus(2'b11, 32'h12345678, 32'h0, hi, lo, dz, lat, sc, sav, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL dz_valid: got %b expected 1", ok); end
    tests++; if (lat != 1) begin fails++; $display("[TB] FAIL dz_latency: got %0d expected 1", lat); end
    tests++; if (sc != 1) begin fails++; $display("[TB] FAIL dz_stall_cycles: got %0d expected 1", sc); end
    tests++;
    if ({dz, hi, lo} !== {1'b1, 32'h12345678, 32'hFFFFFFFF}) begin
      fails++;
      $display("[TB] FAIL dz_result: got dz=%b hi=%h lo=%h expected dz=1 hi=12345678 lo=ffffffff", dz, hi, lo);
    end
    @(negedge clk);
    tests++;
    if ({res_valid_o, div_zero_o} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL dz_flag_clear: got rv=%b dz=%b expected 0 0", res_valid_o, div_zero_o);
    end
  endtask

  task automatic test_cancel();
    logic [W-1:0] hi, lo;
    logic dz, sav, ok, saw;
    int lat, sc;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; src_a_i = 32'd1000; src_b_i = 32'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    @(negedge clk);
    cancel_i = 1'b1;
    tests++; if (stall_o !== 1'b1) begin fails++; $display("[TB] FAIL cancel_stall_before: got %b expected 1", stall_o); end
    @(posedge clk);
    #1;
    cancel_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy_o, stall_o, res_valid_o} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL cancel_idle: got bz=%b st=%b rv=%b expected 0 0 0", busy_o, stall_o, res_valid_o);
    end
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid_o) saw = 1'b1;
    end
    tests++; if (saw !== 1'b0) begin fails++; $display("[TB] FAIL cancel_no_pulse: got %b expected 0", saw); end
    applyStimulus(2'b01, 32'd6, 32'd7, hi, lo, dz, lat, sc, sav, ok);
    tests++;
    if ({ok, hi, lo} !== {1'b1, 32'd0, 32'd42}) begin
      fails++;
      $display("[TB] FAIL cancel_then_multu: got v=%b hi=%0d lo=%0d expected v=1 hi=0 lo=42", ok, hi, lo);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] hi, lo;
    logic dz, sav, ok;
    int lat, sc;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; src_a_i = 32'h0000FFFF; src_b_i = 32'h00010001;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({stall_o, busy_o, res_valid_o, div_zero_o, hi_o, lo_o} !== '0) begin
      fails++;
      $display("[TB] FAIL async_reset: got st=%b bz=%b rv=%b dz=%b hi=%h lo=%h expected all 0",
               stall_o, busy_o, res_valid_o, div_zero_o, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, hi, lo, dz, lat, sc, sav, ok);
    tests++;
    if ({ok, dz, hi, lo} !== {1'b1, 1'b0, 32'h0, 32'h80000000}) begin
      fails++;
      $display("[TB] FAIL div_overflow: got v=%b dz=%b hi=%h lo=%h expected v=1 dz=0 hi=00000000 lo=80000000", ok, dz, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    int lat;
    logic [W-1:0] hi, lo;
    ok = 1'b0; lat = 0; hi = '0; lo = '0;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; src_a_i = 32'd5; src_b_i = 32'd9;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 100 && !ok; c++) begin
      @(negedge clk);
      if (res_valid_o) begin ok = 1'b1; lat = c; lo = lo_o; end
    end
    tests++;
    if ({ok, lo} !== {1'b1, 32'd45} || lat != 34) begin
      fails++;
      $display("[TB] FAIL b2b_first: got v=%b lo=%0d lat=%0d expected v=1 lo=45 lat=34", ok, lo, lat);
    end
    op_i = 2'b11; src_a_i = 32'd100; src_b_i = 32'd7;
    @(negedge clk);
    tests++;
    if ({busy_o, stall_o} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL b2b_idle_gap: got bz=%b st=%b expected bz=0 st=1", busy_o, stall_o);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    ok = 1'b0; lat = 0;
    for (int c = 1; c <= 100 && !ok; c++) begin
      @(negedge clk);
      if (res_valid_o) begin ok = 1'b1; lat = c; hi = hi_o; lo = lo_o; end
    end
    tests++;
    if ({ok, hi, lo} !== {1'b1, 32'd2, 32'd14} || lat != 34) begin
      fails++;
      $display("[TB] FAIL b2b_second: got v=%b hi=%0d lo=%0d lat=%0d expected v=1 hi=2 lo=14 lat=34", ok, hi, lo, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] hi, lo, ehi, elo, a, b;
    logic dz, edz, sav, ok;
    logic [1:0] op;
    int lat, elat, sc, sel;
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case (sel)
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      model(op, a, b, ehi, elo, edz, elat);
      applyStimulus(op, a, b, hi, lo, dz, lat, sc, sav, ok);
      tests++;
      if ({ok, dz} !== {1'b1, edz} || lat != elat) begin
        fails++;
        $display("[TB] FAIL rand%0d_ctrl op=%0d a=%h b=%h: got v=%b dz=%b lat=%0d expected v=1 dz=%b lat=%0d",
                 n, op, a, b, ok, dz, lat, edz, elat);
      end
      tests++;
      if ({hi, lo} !== {ehi, elo}) begin
        fails++;
        $display("[TB] FAIL rand%0d_result op=%0d a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
                 n, op, a, b, hi, lo, ehi, elo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Sequencer for the shared iterative multiply/divide unit behind the HI/LO register pair.
- Accepts one MULT/MULTU/DIV/DIVU operation per request from the Execute stage.
- Runs a radix-2 shift-add or restoring-division loop and holds the front of the pipeline stalled while it works.
- Presents a one-cycle HI/LO result that the Memory-stage hilo write commits; this keeps HI/LO writes in M, as for every other hilo writer.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH split into HI/LO.
CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  Execute-stage valid mult/div op (decoder hilowrite op, not mthi/mtlo)
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
src_a_i  in  WIDTH  rs operand (multiplicand/dividend)
src_b_i  in  WIDTH  rt operand (multiplier/divisor)
cancel_i  in  1  exception/flush of the owning instruction; aborts operation
stall_o  out  1  stall request to hazard unit (holds D and E)
busy_o  out  1  state != IDLE
res_valid_o  out  1  one-cycle pulse, hi_o/lo_o valid
hi_o  out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
lo_o  out  WIDTH  MULT: product[W-1:0]; DIV: quotient
div_zero_o  out  1  with res_valid_o: divisor was zero

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, internal registers=0; stall_o=0, busy_o=0, res_valid_o=0, hi_o=0, lo_o=0, div_zero_o=0.
- States: IDLE, CALC, SIGN, DONE.
- IDLE, start_i=1, cancel_i=0:
  - Latch op and operand magnitudes: signed ops take two's-complement abs; unsigned ops pass through.
  - Record negate flags:
    - MULT: negate product if sign(a)^sign(b).
    - DIV: negate quotient if sign(a)^sign(b); negate remainder if sign(a).
  - Counter=0.
  - Next state: CALC, or DONE directly if the op is a divide with src_b_i=0.
- IDLE, start_i=1 with cancel_i=1: ignored, stay IDLE.
- CALC, one iteration per cycle, counter++; leave for SIGN after the iteration where counter==WIDTH-1 (exactly WIDTH cycles):
  - Multiply: 2W accumulator, shift-add on multiplier LSB.
  - Divide: restoring; shift {rem,quot} left 1; if rem>=divisor, subtract and set quot LSB.
  - All arithmetic is WIDTH+1 bits so there is no overflow in compare/subtract.
- SIGN (1 cycle): apply negate flags into the output registers.
- DONE (1 cycle): res_valid_o=1; hi_o/lo_o hold the result; next state IDLE.
- Divide by zero: hi_o=src_a_i unmodified, lo_o=all ones, div_zero_o=1; latency 1 cycle (IDLE->DONE).
- Signed overflow case 0x80000000 / -1: lo_o=0x80000000, hi_o=0 (natural wrap, no trap).
- stall_o:
  - Combinational: (IDLE & start_i & ~cancel_i) | CALC | SIGN.
  - Deasserted in DONE so the instruction advances to M on that edge, carrying hi_o/lo_o.
- Latency: start accepted at edge T, then res_valid_o is high in cycle T+WIDTH+2 (34 for WIDTH=32). stall_o is high for exactly WIDTH+2 cycles.
- cancel_i in CALC or SIGN: next state IDLE, no res_valid_o, stall_o drops the next cycle.
- cancel_i in DONE: the pulse is still emitted; the downstream flush discards it.
- start_i while busy: ignored; the hazard unit guarantees it is the same stalled instruction.
- start_i in DONE: ignored; a new op is accepted only from IDLE, so back-to-back ops are spaced by 1 idle cycle.
- hi_o/lo_o hold their last value until the next SIGN/DONE write.
- res_valid_o and div_zero_o are 0 outside DONE.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 cycles res_valid_o=1, hi_o=0xFFFFFFFE, lo_o=0x00000001; stall_o high exactly 34 cycles.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB.
- DIV a=-7 b=2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1); DIVU a=100 b=7 -> lo_o=14, hi_o=2.
- DIVU a=0x12345678 b=0 -> res_valid_o next cycle, div_zero_o=1, hi_o=0x12345678, lo_o=0xFFFFFFFF, stall_o high for 1 cycle.
- DIV started, cancel_i pulsed at CALC iteration 10 -> IDLE next cycle, no res_valid_o, stall_o low. A new MULTU 6*7 two cycles later -> lo_o=42, hi_o=0.
- rst asserted mid-CALC, asynchronously between edges -> all outputs 0 immediately, busy_o=0; DIV 0x80000000/0xFFFFFFFF after release -> lo_o=0x80000000, hi_o=0.
